// File: rtl/adapter_pkg.sv
// Shared definitions for the bus adapters: word-length type and the
// beats-to-bits helper used by both the serializer and this receiver.
package adapter_pkg;

  localparam int SIZE_W = 16;

  typedef logic [SIZE_W-1:0] len_t;

  // Bit length of a word made of `beats` beats of `beat_w` bits each
  function automatic len_t beats_to_bits(input int unsigned beats, input int unsigned beat_w);
    return len_t'(beats * beat_w);
  endfunction

endpackage

// File: rtl/adapter_from_bus_if.sv
// Narrow-beat input side and packed-word output side of the receive adapter.
// The slave modport is the adapter's view; master is whoever surrounds it.
interface adapter_from_bus_if #(
  parameter int WIDTH  = 128,
  parameter int OWIDTH = 32
) ();
  import adapter_pkg::*;

  logic              clear_ena;
  logic              clear_rdy;
  logic              in_enq_ena;
  logic [OWIDTH-1:0] in_enq_v;
  logic              in_enq_last;
  logic              in_enq_rdy;
  logic              out_enq_ena;
  logic [WIDTH-1:0]  out_enq_v;
  len_t              out_enq_size;
  logic              out_enq_rdy;

  modport slave (
    input  clear_ena, in_enq_ena, in_enq_v, in_enq_last, out_enq_rdy,
    output clear_rdy, in_enq_rdy, out_enq_ena, out_enq_v, out_enq_size
  );

  modport master (
    output clear_ena, in_enq_ena, in_enq_v, in_enq_last, out_enq_rdy,
    input  clear_rdy, in_enq_rdy, out_enq_ena, out_enq_v, out_enq_size
  );

endinterface

// File: rtl/adapter_from_bus.sv
// Receive adapter: packs MSB-first narrow beats into one left-aligned word
// with its bit length. An accumulator collects beats while a hold register
// presents the previous word, so one beat per cycle is sustained.
module adapter_from_bus
  import adapter_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int OWIDTH = 32
) (
  input logic               CLK,
  input logic               nRST,
  adapter_from_bus_if.slave bus
);

  localparam int NBEAT = WIDTH / OWIDTH;
  localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEAT - 1);

  logic [WIDTH-1:0] acc, acc_d, merged;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] hold_v, hold_v_d;
  len_t             hold_size, hold_size_d;
  logic             hold_valid, hold_valid_d;
  logic             accept, close, drain;

  assign bus.clear_rdy    = 1'b1;
  assign bus.in_enq_rdy   = !hold_valid || bus.out_enq_rdy;
  assign bus.out_enq_ena  = hold_valid;
  assign bus.out_enq_v    = hold_v;
  assign bus.out_enq_size = hold_size;

  assign accept = bus.in_enq_ena && bus.in_enq_rdy && !bus.clear_ena;
  assign close  = accept && (bus.in_enq_last || cnt == LAST_CNT);
  assign drain  = hold_valid && bus.out_enq_rdy;

  // Next-state decode for accumulator and hold; priority clear > close > drain
  always_comb begin
    merged = acc;
    for (int b = 0; b < NBEAT; b++) begin
      if (cnt == CNT_W'(b)) merged[WIDTH-1-b*OWIDTH -: OWIDTH] = bus.in_enq_v;
    end
    acc_d        = acc;
    cnt_d        = cnt;
    hold_v_d     = hold_v;
    hold_size_d  = hold_size;
    hold_valid_d = hold_valid;
    if (bus.clear_ena) begin
      acc_d        = '0;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
    end else if (close) begin
      hold_v_d     = merged;
      hold_size_d  = beats_to_bits(32'(cnt) + 32'd1, OWIDTH);
      hold_valid_d = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
    end else begin
      if (accept) begin
        acc_d = merged;
        cnt_d = cnt + CNT_W'(1);
      end
      if (drain) hold_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      acc        <= '0;
      cnt        <= '0;
      hold_v     <= '0;
      hold_size  <= '0;
      hold_valid <= 1'b0;
    end else begin
      acc        <= acc_d;
      cnt        <= cnt_d;
      hold_v     <= hold_v_d;
      hold_size  <= hold_size_d;
      hold_valid <= hold_valid_d;
    end
  end

endmodule

// File: tb/tb_adapter_from_bus.sv
// Bench for adapter_from_bus: directed vector table, hand-written corner
// sequences, and random traffic against a queue-based reference model.
module tb_adapter_from_bus;

  localparam int W  = 128;
  localparam int OW = 32;
  localparam int NB = W / OW;

  typedef struct {
    logic [W-1:0] v;
    logic [15:0]  size;
  } word_t;

  typedef struct {
    logic          ena;
    logic [OW-1:0] v;
    logic          last;
    logic          ordy;
    logic          exp_ena;
    logic [W-1:0]  exp_v;
    logic [15:0]   exp_size;
    logic          exp_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic nrst;

  adapter_from_bus_if #(.WIDTH(W), .OWIDTH(OW)) bus ();

  adapter_from_bus #(.WIDTH(W), .OWIDTH(OW)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.slave)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  int          pass_count = 0;
  int          check_count = 0;
  bit          model_live = 0;
  logic [OW-1:0] beats[$];
  word_t       exp_q[$];
  vec_t        vecs[$];

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
  endtask

  // Compare DUT against model before the edge, then advance the model
  task automatic applyStimulus(input logic ena, input logic [OW-1:0] v, input logic last,
                               input logic ordy, input logic clr);
    word_t w;
    bit    rdy_m;
    bus.in_enq_ena  = ena;
    bus.in_enq_v    = v;
    bus.in_enq_last = last;
    bus.out_enq_rdy = ordy;
    bus.clear_ena   = clr;
    @(negedge clk);
    if (model_live && nrst) begin
      rdy_m = (exp_q.size() == 0) || ordy;
      checkOutput("model rdy", W'(bus.in_enq_rdy), W'(rdy_m));
      checkOutput("model ena", W'(bus.out_enq_ena), W'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        checkOutput("model v", bus.out_enq_v, exp_q[0].v);
        checkOutput("model size", W'(bus.out_enq_size), W'(exp_q[0].size));
      end
    end
    if (!nrst) begin
      beats.delete();
      exp_q.delete();
      model_live = 1;
    end else if (model_live) begin
      rdy_m = (exp_q.size() == 0) || ordy;
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (clr) begin
        beats.delete();
        exp_q.delete();
      end else if (ena && rdy_m) begin
        beats.push_back(v);
        if (last || beats.size() == NB) begin
          w.v = '0;
          for (int i = 0; i < beats.size(); i++) w.v[W-1-i*OW -: OW] = beats[i];
          w.size = 16'(beats.size() * OW);
          exp_q.push_back(w);
          beats.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OW-1:0] c_beats[6];
    logic          ordy, clr, ena;

    nrst = 1'b0;
    applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("reset ena", W'(bus.out_enq_ena), '0);
    checkOutput("reset v", bus.out_enq_v, '0);
    checkOutput("reset size", W'(bus.out_enq_size), '0);
    checkOutput("reset rdy", W'(bus.in_enq_rdy), W'(1));
    checkOutput("clear_rdy", W'(bus.clear_rdy), W'(1));
    nrst = 1'b1;

    // Four-beat word, two-beat word, then stalled single-beat words
    vecs.push_back('{1'b1, 32'hAAAA0001, 1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1});
    vecs.push_back('{1'b1, 32'hAAAA0002, 1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1});
    vecs.push_back('{1'b1, 32'hAAAA0003, 1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1});
    vecs.push_back('{1'b1, 32'hAAAA0004, 1'b1, 1'b1, 1'b1,
                     128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004, 16'd128, 1'b1});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1});
    vecs.push_back('{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1});
    vecs.push_back('{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1,
                     128'h11111111_22222222_00000000_00000000, 16'd64, 1'b1});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1});
    vecs.push_back('{1'b1, 32'hB0000001, 1'b1, 1'b0, 1'b1,
                     128'hB0000001_00000000_00000000_00000000, 16'd32, 1'b0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b1,
                       128'hB0000001_00000000_00000000_00000000, 16'd32, 1'b0});
    vecs.push_back('{1'b1, 32'hB0000002, 1'b1, 1'b1, 1'b1,
                     128'hB0000002_00000000_00000000_00000000, 16'd32, 1'b1});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ena, vecs[i].v, vecs[i].last, vecs[i].ordy, 1'b0);
      checkOutput($sformatf("vec%0d ena", i), W'(bus.out_enq_ena), W'(vecs[i].exp_ena));
      checkOutput($sformatf("vec%0d rdy", i), W'(bus.in_enq_rdy), W'(vecs[i].exp_rdy));
      if (vecs[i].exp_ena) begin
        checkOutput($sformatf("vec%0d v", i), bus.out_enq_v, vecs[i].exp_v);
        checkOutput($sformatf("vec%0d size", i), W'(bus.out_enq_size), W'(vecs[i].exp_size));
      end
    end

    // Auto-close after a full word, then a two-beat word
    for (int i = 0; i < 6; i++) c_beats[i] = 32'hC0000001 + 32'(i);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, c_beats[i], i == 5, 1, 0);
      checkOutput($sformatf("auto rdy%0d", i), W'(bus.in_enq_rdy), W'(1));
      if (i == 3) begin
        checkOutput("auto ena", W'(bus.out_enq_ena), W'(1));
        checkOutput("auto v", bus.out_enq_v, 128'hC0000001_C0000002_C0000003_C0000004);
        checkOutput("auto size", W'(bus.out_enq_size), W'(128));
      end
    end
    checkOutput("tail ena", W'(bus.out_enq_ena), W'(1));
    checkOutput("tail v", bus.out_enq_v, 128'hC0000005_C0000006_00000000_00000000);
    checkOutput("tail size", W'(bus.out_enq_size), W'(64));
    applyStimulus(0, '0, 0, 1, 0);

    // Clear mid-word with a beat in the same cycle
    applyStimulus(1, 32'hD0000001, 0, 1, 0);
    applyStimulus(1, 32'hD0000002, 0, 1, 0);
    applyStimulus(1, 32'hD0000003, 1, 1, 1);
    checkOutput("clear ena", W'(bus.out_enq_ena), '0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'hE0000001 + 32'(i), i == 3, 1, 0);
    checkOutput("post-clear ena", W'(bus.out_enq_ena), W'(1));
    checkOutput("post-clear v", bus.out_enq_v, 128'hE0000001_E0000002_E0000003_E0000004);
    checkOutput("post-clear size", W'(bus.out_enq_size), W'(128));
    applyStimulus(0, '0, 0, 1, 0);

    // Reset mid-word, then reset with the hold full
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'hF0000001 + 32'(i), 0, 1, 0);
    nrst = 1'b0;
    applyStimulus(1, 32'hF0000004, 1, 1, 0);
    nrst = 1'b1;
    checkOutput("rst-mid ena", W'(bus.out_enq_ena), '0);
    checkOutput("rst-mid v", bus.out_enq_v, '0);
    checkOutput("rst-mid size", W'(bus.out_enq_size), '0);
    applyStimulus(1, 32'h90000001, 1, 0, 0);
    checkOutput("hold full ena", W'(bus.out_enq_ena), W'(1));
    nrst = 1'b0;
    applyStimulus(0, '0, 0, 0, 0);
    nrst = 1'b1;
    checkOutput("rst-hold ena", W'(bus.out_enq_ena), '0);
    checkOutput("rst-hold v", bus.out_enq_v, '0);
    checkOutput("rst-hold size", W'(bus.out_enq_size), '0);
    checkOutput("rst-hold rdy", W'(bus.in_enq_rdy), W'(1));
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h50000001 + 32'(i), i == 3, 1, 0);
    checkOutput("clean v", bus.out_enq_v, 128'h50000001_50000002_50000003_50000004);
    checkOutput("clean size", W'(bus.out_enq_size), W'(128));

    // Random traffic with stalls, clears and occasional resets
    for (int n = 0; n < 3000; n++) begin
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 47) == 0);
      ena  = ((exp_q.size() == 0) || ordy) && ($urandom_range(0, 3) != 0);
      nrst = ($urandom_range(0, 499) != 0);
      applyStimulus(ena, OW'($urandom), $urandom_range(0, 3) == 0, ordy, clr);
    end
    nrst = 1'b1;
    applyStimulus(0, '0, 0, 1, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
